// File: rtl/big_merge_arb.sv
// Round-robin merge of N_IN valid/ready producers into one registered output slot.
// Define BIG_MERGE_ARB_STATS_EN to add saturating per-input grant counters (grant_cnt).
module big_merge_arb #(
    parameter int WIDTH = 11,
    parameter int N_IN  = 5,
    parameter int SRC_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       in_valid,
    input  logic [N_IN*WIDTH-1:0] in_data,
    output logic [N_IN-1:0]       in_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SRC_W-1:0]      out_src,
    input  logic                  out_ready
`ifdef BIG_MERGE_ARB_STATS_EN
    ,
    output logic [N_IN*16-1:0]    grant_cnt
`endif
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [SRC_W-1:0] rr_q, rr_d;
    logic             accept;
    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic             grant;

    assign accept = !valid_q || out_ready;
    assign grant  = accept && win_found && !reset;

    // Search from rr_q upward, wrapping, and take the first valid input.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < N_IN; k++) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= N_IN) idx = idx - N_IN;
            if (!win_found && in_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = SRC_W'(idx);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (grant) in_ready = N_IN'(1) << win_idx;
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (accept) begin
            if (win_found) begin
                valid_d = 1'b1;
                data_d  = in_data[int'(win_idx)*WIDTH +: WIDTH];
                src_d   = win_idx;
                rr_d    = (win_idx == SRC_W'(N_IN-1)) ? '0 : win_idx + 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
            rr_q    <= rr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

`ifdef BIG_MERGE_ARB_STATS_EN
    logic [15:0] cnt_q [N_IN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (in_valid[i] && in_ready[i] && cnt_q[i] != 16'hFFFF)
                    cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule
